// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the mm:ss countdown timer.
// State encoding, BCD limits and the BCD range check live here.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [7:0] BCD_00 = 8'h00;
    localparam logic [7:0] BCD_01 = 8'h01;
    localparam logic [7:0] BCD_59 = 8'h59;

    // True when v is a legal 00-59 BCD value.
    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_down_60.sv
// BCD mod-60 down counter with parallel load.
// borrow is high when an enabled step wraps 00 -> 59.
module bcd_down_60
    import countdown_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic [7:0] val,
    output logic       borrow
);

    logic [7:0] val_q;
    logic [7:0] val_d;

    // Next value: load wins, otherwise one BCD step down on enable.
    always_comb begin
        val_d = val_q;
        if (load) begin
            val_d = load_val;
        end else if (en) begin
            if (val_q == BCD_00) begin
                val_d = BCD_59;
            end else if (val_q[3:0] != 4'd0) begin
                val_d = {val_q[7:4], val_q[3:0] - 4'd1};
            end else begin
                val_d = {val_q[7:4] - 4'd1, 4'd9};
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val_q <= BCD_00;
        end else begin
            val_q <= val_d;
        end
    end

    assign val    = val_q;
    assign borrow = en && (val_q == BCD_00);

endmodule

// File: rtl/countdown_timer.sv
// mm:ss BCD countdown timer with start/pause/load control.
// Prescaler and control FSM; digits held in two bcd_down_60.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] preset_min,
    input  logic [7:0] preset_sec,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       running,
    output logic       alarm,
    output logic       sec_borrow,
    output logic       load_err
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d;
    logic          alarm_q, alarm_d;
    logic          borrow_q, borrow_d;
    logic          err_q, err_d;

    logic          load_ok;
    logic          cnt_load;
    logic          tick;
    logic          at_zero;
    logic          sec_wrap;
    logic          min_wrap;

    assign load_ok = load && bcd_valid(preset_min)
                          && bcd_valid(preset_sec);
    assign at_zero = (min == BCD_00) && (sec == BCD_00);

    // Next state, prescaler and digit-load control.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        tick     = 1'b0;
        cnt_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    if (load_ok) begin
                        cnt_load = 1'b1;
                        presc_d  = '0;
                    end
                end else if (start && !at_zero) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
            end
            ST_RUN: begin
                if (presc_q == LAST) begin
                    tick    = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                if (tick && (min == BCD_00) && (sec == BCD_01)) begin
                    state_d = ST_DONE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (load) begin
                    if (load_ok) begin
                        cnt_load = 1'b1;
                        presc_d  = '0;
                        state_d  = ST_IDLE;
                    end
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (load_ok) begin
                    cnt_load = 1'b1;
                    presc_d  = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered status outputs follow the next state.
    always_comb begin
        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_DONE);
        borrow_d  = sec_wrap;
        err_d     = load && !load_ok && (state_q != ST_RUN);
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
            borrow_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
            borrow_q  <= borrow_d;
            err_q     <= err_d;
        end
    end

    bcd_down_60 u_sec (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (preset_sec),
        .en       (tick),
        .val      (sec),
        .borrow   (sec_wrap)
    );

    bcd_down_60 u_min (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (preset_min),
        .en       (sec_wrap),
        .val      (min),
        .borrow   (min_wrap)
    );

    assign running    = running_q;
    assign alarm      = alarm_q;
    assign sec_borrow = borrow_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (TICK_DIV = 4).
// Table vectors, directed sequences and a seconds-based model.
module tb_countdown_timer;

    localparam int TD = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [7:0] preset_min = 8'h00;
    logic [7:0] preset_sec = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] min;
    logic [7:0] sec;
    logic       running;
    logic       alarm;
    logic       sec_borrow;
    logic       load_err;

    int checks = 0;
    int errors = 0;

    int m_t;
    int m_st;
    int m_pre;
    bit m_bor;
    bit m_err;

    typedef struct {
        logic       l;
        logic [7:0] pm;
        logic [7:0] ps;
        logic       st;
        logic       pa;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[18];

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .preset_min (preset_min),
        .preset_sec (preset_sec),
        .start      (start),
        .pause      (pause),
        .min        (min),
        .sec        (sec),
        .running    (running),
        .alarm      (alarm),
        .sec_borrow (sec_borrow),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    function automatic bit ok60(input logic [7:0] v);
        return (int'(v) / 16 <= 5) && (int'(v) % 16 <= 9);
    endfunction

    function automatic logic [7:0] to_bcd(input int x);
        return 8'((x / 10) * 16 + (x % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] v);
        return (int'(v) / 16) * 10 + (int'(v) % 16);
    endfunction

    function automatic logic [19:0] dut_vec();
        return {min, sec, running, alarm, sec_borrow, load_err};
    endfunction

    function automatic logic [19:0] model_vec();
        return {to_bcd(m_t / 60), to_bcd(m_t % 60),
                m_st == M_RUN, m_st == M_DONE, m_bor, m_err};
    endfunction

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, a, e, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0;
        m_st = M_IDLE;
        m_pre = 0;
        m_bor = 0;
        m_err = 0;
    endtask

    task automatic model_step(input bit l, input logic [7:0] pm,
                              input logic [7:0] ps, input bit st,
                              input bit pa);
        bit ok;
        ok = l && ok60(pm) && ok60(ps);
        m_err = l && !ok && (m_st != M_RUN);
        m_bor = 0;
        case (m_st)
            M_IDLE: begin
                if (l) begin
                    if (ok) begin
                        m_t = from_bcd(pm) * 60 + from_bcd(ps);
                        m_pre = 0;
                    end
                end else if (st && m_t != 0) begin
                    m_st = M_RUN;
                    m_pre = 0;
                end
            end
            M_RUN: begin
                if (m_pre == TD - 1) begin
                    m_pre = 0;
                    if (m_t % 60 == 0) m_bor = 1;
                    m_t = m_t - 1;
                    if (m_t == 0) m_st = M_DONE;
                end else begin
                    m_pre = m_pre + 1;
                end
                if (m_st == M_RUN && pa) m_st = M_PAUSE;
            end
            M_PAUSE: begin
                if (l) begin
                    if (ok) begin
                        m_t = from_bcd(pm) * 60 + from_bcd(ps);
                        m_pre = 0;
                        m_st = M_IDLE;
                    end
                end else if (st) begin
                    m_st = M_RUN;
                end
            end
            default: begin
                if (ok) begin
                    m_t = from_bcd(pm) * 60 + from_bcd(ps);
                    m_pre = 0;
                    m_st = M_IDLE;
                end
            end
        endcase
    endtask

    // One clock: drive, step the model at the edge, compare at negedge.
    task automatic cyc(input bit l, input logic [7:0] pm,
                       input logic [7:0] ps, input bit st,
                       input bit pa);
        load = l;
        preset_min = pm;
        preset_sec = ps;
        start = st;
        pause = pa;
        @(posedge clk);
        model_step(l, pm, ps, st, pa);
        @(negedge clk);
        chk("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 8'h00, 0, 0);
    endtask

    int nbor;

    initial begin
        tbl[0]  = '{0, 8'h00, 8'h00, 0, 0, {8'h00, 8'h00, 4'b0000}};
        tbl[1]  = '{0, 8'h00, 8'h00, 1, 0, {8'h00, 8'h00, 4'b0000}};
        tbl[2]  = '{1, 8'h00, 8'h60, 0, 0, {8'h00, 8'h00, 4'b0001}};
        tbl[3]  = '{1, 8'h5A, 8'h00, 0, 0, {8'h00, 8'h00, 4'b0001}};
        tbl[4]  = '{0, 8'h00, 8'h00, 0, 0, {8'h00, 8'h00, 4'b0000}};
        tbl[5]  = '{1, 8'h00, 8'h02, 0, 0, {8'h00, 8'h02, 4'b0000}};
        tbl[6]  = '{0, 8'h00, 8'h00, 1, 0, {8'h00, 8'h02, 4'b1000}};
        tbl[7]  = '{0, 8'h00, 8'h00, 0, 0, {8'h00, 8'h02, 4'b1000}};
        tbl[8]  = '{0, 8'h00, 8'h00, 0, 0, {8'h00, 8'h02, 4'b1000}};
        tbl[9]  = '{0, 8'h00, 8'h00, 0, 0, {8'h00, 8'h02, 4'b1000}};
        tbl[10] = '{0, 8'h00, 8'h00, 0, 0, {8'h00, 8'h01, 4'b1000}};
        tbl[11] = '{0, 8'h00, 8'h00, 0, 0, {8'h00, 8'h01, 4'b1000}};
        tbl[12] = '{0, 8'h00, 8'h00, 0, 0, {8'h00, 8'h01, 4'b1000}};
        tbl[13] = '{0, 8'h00, 8'h00, 0, 0, {8'h00, 8'h01, 4'b1000}};
        tbl[14] = '{0, 8'h00, 8'h00, 0, 0, {8'h00, 8'h00, 4'b0100}};
        tbl[15] = '{0, 8'h00, 8'h00, 1, 1, {8'h00, 8'h00, 4'b0100}};
        tbl[16] = '{1, 8'h00, 8'h5A, 0, 0, {8'h00, 8'h00, 4'b0101}};
        tbl[17] = '{1, 8'h00, 8'h00, 0, 0, {8'h00, 8'h00, 4'b0000}};

        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", 32'(dut_vec()), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].l, tbl[i].pm, tbl[i].ps, tbl[i].st, tbl[i].pa);
            chk($sformatf("tbl%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
        end

        // 01:00 -> 00:59 after four clocks, then all the way down.
        cyc(1, 8'h01, 8'h00, 0, 0);
        cyc(0, 8'h00, 8'h00, 1, 0);
        nbor = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 8'h00, 8'h00, 0, 0);
            if (sec_borrow) nbor++;
        end
        chk("m1_first_tick", {min, sec, 7'b0, sec_borrow},
            {8'h00, 8'h59, 8'h01});
        for (int i = 4; i < 240; i++) begin
            cyc(0, 8'h00, 8'h00, 0, 0);
            if (sec_borrow) nbor++;
        end
        chk("m1_done", {min, sec, 6'b0, running, alarm},
            {8'h00, 8'h00, 8'h01});
        chk("m1_borrows", nbor, 1);
        cyc(1, 8'h00, 8'h00, 0, 0);

        // 00:10, pause coincident with the second tick, then resume.
        cyc(1, 8'h00, 8'h10, 0, 0);
        cyc(0, 8'h00, 8'h00, 1, 0);
        idle(7);
        cyc(0, 8'h00, 8'h00, 0, 1);
        chk("p_paused", {min, sec, running}, {8'h00, 8'h08, 1'b0});
        idle(20);
        chk("p_held", {min, sec, running}, {8'h00, 8'h08, 1'b0});
        cyc(0, 8'h00, 8'h00, 1, 0);
        idle(31);
        chk("p_not_yet", {sec, alarm}, {8'h01, 1'b0});
        idle(1);
        chk("p_done", {sec, running, alarm}, {8'h00, 2'b01});

        // Asynchronous reset between edges while at 00:37.
        cyc(1, 8'h00, 8'h40, 0, 0);
        cyc(0, 8'h00, 8'h00, 1, 0);
        idle(12);
        chk("r_at37", {min, sec, running}, {8'h00, 8'h37, 1'b1});
        #2 reset = 1'b0;
        #1;
        chk("r_async", 32'(dut_vec()), 32'h0);
        model_reset();
        @(negedge clk);
        chk("r_held", 32'(dut_vec()), 32'h0);
        reset = 1'b1;
        cyc(1, 8'h00, 8'h05, 0, 0);
        chk("r_first_load", {min, sec}, {8'h00, 8'h05});

        // Load ignored in RUN, start+pause pauses, load from DONE.
        cyc(1, 8'h00, 8'h20, 0, 0);
        cyc(0, 8'h00, 8'h00, 1, 0);
        idle(5);
        cyc(1, 8'h05, 8'h00, 0, 0);
        chk("x_load_ign", {min, running, load_err}, {8'h00, 2'b10});
        idle(3);
        cyc(0, 8'h00, 8'h00, 1, 1);
        chk("x_both_pause", {running, alarm}, 2'b00);
        idle(6);
        cyc(0, 8'h00, 8'h00, 1, 0);
        for (int i = 0; i < 200 && !alarm; i++) idle(1);
        chk("x_reached_done", alarm, 1'b1);
        cyc(1, 8'h03, 8'h00, 0, 0);
        chk("x_done_load", {min, sec, running, alarm},
            {8'h03, 8'h00, 2'b00});

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] pm, ps;
            pm = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                             : to_bcd($urandom_range(0, 1));
            ps = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                             : to_bcd($urandom_range(0, 25));
            cyc($urandom_range(0, 15) == 0, pm, ps,
                $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
